// File: rtl/wdt_multi_ch.sv
// Multi-channel watchdog timer: per-channel up-counter, timeout, kick, lock and
// sticky interrupt, a shared count-tick prescaler and a single-cycle register port.
module wdt_multi_ch #(
   parameter int  NUM_CH   = 2,
   parameter int  CNT_W    = 32,
   parameter int  PRESCALE = 1,
   localparam int ADDR_W   = $clog2(NUM_CH) + 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wen,
   input  logic              ren,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              rvalid,
   output logic [NUM_CH-1:0] wto_irq,
   output logic              wto_any
);

   localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   typedef enum logic [1:0] {
      OFF_CTRL    = 2'd0,
      OFF_TIMEOUT = 2'd1,
      OFF_KICK    = 2'd2,
      OFF_STATUS  = 2'd3
   } reg_off_e;

   logic [PS_W-1:0]   presc_q, presc_d;
   logic              tick;
   logic [NUM_CH-1:0] en_q, en_d;
   logic [NUM_CH-1:0] lock_q, lock_d;
   logic [NUM_CH-1:0] irq_q, irq_d;
   logic [CNT_W-1:0]  timeout_q [NUM_CH];
   logic [CNT_W-1:0]  timeout_d [NUM_CH];
   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_d [NUM_CH];
   logic [NUM_CH-1:0] running, expire, wr_sel;
   logic [31:0]       rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;
   logic              wto_any_q, wto_any_d;
   logic              ch_ok;
   int                ch_sel;
   reg_off_e          off;

   // Address decode, prescaler tick and per-channel status terms.
   always_comb begin
      ch_sel  = int'(addr >> 2);
      ch_ok   = (ch_sel < NUM_CH);
      off     = reg_off_e'(addr[1:0]);
      tick    = (presc_q == PS_W'(PRESCALE - 1));
      presc_d = tick ? '0 : presc_q + 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         wr_sel[i]  = wen && ch_ok && (ch_sel == i);
         running[i] = en_q[i] && (timeout_q[i] != '0);
         expire[i]  = tick && running[i] && (cnt_q[i] >= timeout_q[i] - 1'b1);
      end
   end

   // Channel state: counting first, then a register write overrides it.
   always_comb begin
      // NOTE: every output of this block gets its hold value first, so no path leaves it unassigned and no latch is inferred.
      en_d   = en_q;
      lock_d = lock_q;
      irq_d  = irq_q;
      for (int i = 0; i < NUM_CH; i++) begin
         timeout_d[i] = timeout_q[i];
         cnt_d[i]     = cnt_q[i];
         if (tick && running[i]) begin
            cnt_d[i] = expire[i] ? '0 : cnt_q[i] + 1'b1;
         end
         if (expire[i]) begin
            irq_d[i] = 1'b1;
         end
         if (wr_sel[i]) begin
            unique case (off)
               OFF_CTRL: begin
                  lock_d[i] = lock_q[i] | wdata[1];
                  if (!lock_q[i]) begin
                     en_d[i]  = wdata[0];
                     cnt_d[i] = (wdata[0] && en_q[i]) ? cnt_q[i] : '0;
                     irq_d[i] = irq_q[i];
                  end
               end
               OFF_TIMEOUT: begin
                  if (!lock_q[i]) begin
                     timeout_d[i] = wdata[CNT_W-1:0];
                     cnt_d[i]     = '0;
                     irq_d[i]     = irq_q[i];
                  end
               end
               OFF_KICK: begin
                  cnt_d[i] = '0;
                  irq_d[i] = irq_q[i];
               end
               OFF_STATUS: begin
                  // A same-edge expiry keeps the interrupt set.
                  if (wdata[0] && !expire[i]) begin
                     irq_d[i] = 1'b0;
                  end
               end
            endcase
         end
      end
   end

   // Read port returns pre-write state; rdata holds between reads.
   always_comb begin
      rdata_d   = rdata_q;
      rvalid_d  = ren;
      wto_any_d = |irq_q;
      if (ren) begin
         rdata_d = '0;
         for (int i = 0; i < NUM_CH; i++) begin
            if (ch_ok && (ch_sel == i)) begin
               unique case (off)
                  OFF_CTRL:    rdata_d = {30'd0, lock_q[i], en_q[i]};
                  OFF_TIMEOUT: rdata_d = 32'(timeout_q[i]);
                  OFF_KICK:    rdata_d = 32'(cnt_q[i]);
                  OFF_STATUS:  rdata_d = {30'd0, running[i], irq_q[i]};
               endcase
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_q   <= '0;
         en_q      <= '0;
         lock_q    <= '0;
         irq_q     <= '0;
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
         wto_any_q <= 1'b0;
         // NOTE: the per-channel arrays are plain flop banks, not RAM, so each entry is reset explicitly.
         for (int i = 0; i < NUM_CH; i++) begin
            timeout_q[i] <= '0;
            cnt_q[i]     <= '0;
         end
      end else begin
         presc_q   <= presc_d;
         en_q      <= en_d;
         lock_q    <= lock_d;
         irq_q     <= irq_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
         wto_any_q <= wto_any_d;
         for (int i = 0; i < NUM_CH; i++) begin
            timeout_q[i] <= timeout_d[i];
            cnt_q[i]     <= cnt_d[i];
         end
      end
   end

   assign rdata   = rdata_q;
   assign rvalid  = rvalid_q;
   assign wto_irq = irq_q;
   assign wto_any = wto_any_q;

endmodule

// File: tb/tb_wdt_multi_ch.sv
// Directed bench for wdt_multi_ch: a per-cycle vector table on a 3-channel,
// PRESCALE=1 instance plus hand sequences for reset and a PRESCALE=4 instance.
module tb_wdt_multi_ch;

   typedef struct {
      logic        wen;
      logic        ren;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic        chk_rd;
      logic [31:0] exp_rdata;
      logic [2:0]  exp_irq;
      logic        exp_any;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wen = 1'b0, ren = 1'b0;
   logic [3:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        rvalid;
   logic [2:0]  wto_irq;
   logic        wto_any;

   logic        wen4 = 1'b0, ren4 = 1'b0;
   logic [2:0]  addr4 = '0;
   logic [31:0] wdata4 = '0;
   logic [31:0] rdata4;
   logic        rvalid4;
   logic [1:0]  wto_irq4;
   logic        wto_any4;

   int   n_checks = 0;
   int   n_errors = 0;
   int   edge_cnt = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   wdt_multi_ch #(.NUM_CH(3), .CNT_W(16), .PRESCALE(1)) dut (
      .clk(clk), .rst(rst), .wen(wen), .ren(ren), .addr(addr), .wdata(wdata),
      .rdata(rdata), .rvalid(rvalid), .wto_irq(wto_irq), .wto_any(wto_any)
   );

   wdt_multi_ch #(.NUM_CH(2), .CNT_W(8), .PRESCALE(4)) dut4 (
      .clk(clk), .rst(rst), .wen(wen4), .ren(ren4), .addr(addr4), .wdata(wdata4),
      .rdata(rdata4), .rvalid(rvalid4), .wto_irq(wto_irq4), .wto_any(wto_any4)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      edge_cnt++;
   endtask

   task automatic add(input logic w, input logic r, input logic [3:0] a, input logic [31:0] d,
                      input logic c, input logic [31:0] erd, input logic [2:0] ei, input logic ea);
      vec_t v;
      v.wen = w; v.ren = r; v.addr = a; v.wdata = d;
      v.chk_rd = c; v.exp_rdata = erd; v.exp_irq = ei; v.exp_any = ea;
      vecs.push_back(v);
   endtask

   task automatic add_idle(input int n, input logic [2:0] ei, input logic ea);
      for (int k = 0; k < n; k++) add(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, ei, ea);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      // Channel addresses: ch0 0..3, ch1 4..7, ch2 8..11, 12..15 unmapped.
      //    wen   ren   addr   wdata   chk  rdata  irq     any
      add(1'b0, 1'b1, 4'd3,  32'd0,  1'b1, 32'd0, 3'b000, 1'b0); // status after reset
      add(1'b1, 1'b0, 4'd1,  32'd5,  1'b0, 32'd0, 3'b000, 1'b0); // ch0 TIMEOUT=5
      add(1'b1, 1'b0, 4'd0,  32'd1,  1'b0, 32'd0, 3'b000, 1'b0); // EN at edge 0
      add_idle(4, 3'b000, 1'b0);
      add_idle(1, 3'b001, 1'b0);                                  // expiry at edge 5
      add_idle(1, 3'b001, 1'b1);                                  // wto_any one later
      add(1'b1, 1'b0, 4'd3,  32'd1,  1'b0, 32'd0, 3'b000, 1'b1); // W1C
      add(1'b1, 1'b0, 4'd1,  32'd5,  1'b0, 32'd0, 3'b000, 1'b0); // TIMEOUT rewrite
      add_idle(3, 3'b000, 1'b0);
      add(1'b1, 1'b0, 4'd2,  32'd0,  1'b0, 32'd0, 3'b000, 1'b0); // KICK at edge 4
      add_idle(4, 3'b000, 1'b0);
      add(1'b1, 1'b0, 4'd2,  32'd0,  1'b0, 32'd0, 3'b000, 1'b0); // KICK on expiry edge
      add(1'b0, 1'b1, 4'd2,  32'd0,  1'b1, 32'd0, 3'b000, 1'b0); // counter 0
      add(1'b0, 1'b1, 4'd2,  32'd0,  1'b1, 32'd1, 3'b000, 1'b0); // counter 1
      add(1'b0, 1'b0, 4'd0,  32'd0,  1'b1, 32'd1, 3'b000, 1'b0); // rdata held
      add_idle(1, 3'b000, 1'b0);
      add_idle(1, 3'b001, 1'b0);
      add_idle(4, 3'b001, 1'b1);
      add(1'b1, 1'b0, 4'd3,  32'd1,  1'b0, 32'd0, 3'b001, 1'b1); // W1C vs expiry
      add(1'b1, 1'b0, 4'd3,  32'd1,  1'b0, 32'd0, 3'b000, 1'b1); // plain W1C
      add_idle(1, 3'b000, 1'b0);
      add(1'b1, 1'b0, 4'd0,  32'd0,  1'b0, 32'd0, 3'b000, 1'b0); // ch0 disable
      add(1'b1, 1'b0, 4'd5,  32'd3,  1'b0, 32'd0, 3'b000, 1'b0); // ch1 TIMEOUT=3
      add(1'b1, 1'b0, 4'd4,  32'd3,  1'b0, 32'd0, 3'b000, 1'b0); // EN+LOCK
      add(1'b1, 1'b0, 4'd4,  32'd0,  1'b0, 32'd0, 3'b000, 1'b0); // ignored
      add(1'b1, 1'b0, 4'd5,  32'd100,1'b0, 32'd0, 3'b000, 1'b0); // ignored
      add(1'b0, 1'b1, 4'd4,  32'd0,  1'b1, 32'd3, 3'b010, 1'b0); // CTRL=3, expiry
      add(1'b0, 1'b1, 4'd5,  32'd0,  1'b1, 32'd3, 3'b010, 1'b1); // TIMEOUT kept
      add(1'b0, 1'b1, 4'd7,  32'd0,  1'b1, 32'd3, 3'b010, 1'b1); // RUNNING+IRQ
      add(1'b1, 1'b1, 4'd7,  32'd1,  1'b1, 32'd3, 3'b010, 1'b1); // rd/wr same addr
      add_idle(1, 3'b010, 1'b1);
      add(1'b1, 1'b1, 4'd6,  32'd0,  1'b1, 32'd1, 3'b010, 1'b1); // pre-kick count
      add(1'b0, 1'b1, 4'd6,  32'd0,  1'b1, 32'd0, 3'b010, 1'b1);
      add(1'b0, 1'b1, 4'd4,  32'd0,  1'b1, 32'd3, 3'b010, 1'b1);
      add(1'b0, 1'b1, 4'd13, 32'd0,  1'b1, 32'd0, 3'b010, 1'b1); // unmapped read
      add(1'b0, 1'b1, 4'd4,  32'd0,  1'b1, 32'd3, 3'b010, 1'b1);

      repeat (3) @(posedge clk);
      #1;
      check("reset rdata", rdata, 32'd0);
      check("reset rvalid", 32'(rvalid), 32'd0);
      check("reset irq", 32'(wto_irq), 32'd0);
      check("reset any", 32'(wto_any), 32'd0);
      check("reset irq4", 32'(wto_irq4), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      edge_cnt = 0;

      for (int i = 0; i < vecs.size(); i++) begin
         wen = vecs[i].wen; ren = vecs[i].ren; addr = vecs[i].addr; wdata = vecs[i].wdata;
         step();
         check($sformatf("v%0d rvalid", i), 32'(rvalid), 32'(vecs[i].ren));
         if (vecs[i].chk_rd) check($sformatf("v%0d rdata", i), rdata, vecs[i].exp_rdata);
         check($sformatf("v%0d irq", i), 32'(wto_irq), 32'(vecs[i].exp_irq));
         check($sformatf("v%0d any", i), 32'(wto_any), 32'(vecs[i].exp_any));
      end
      wen = 1'b0; ren = 1'b0;

      // Asynchronous reset mid-count with ch1 interrupt pending.
      #2;
      rst = 1'b0;
      #1;
      check("async rdata", rdata, 32'd0);
      check("async rvalid", 32'(rvalid), 32'd0);
      check("async irq", 32'(wto_irq), 32'd0);
      check("async any", 32'(wto_any), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      edge_cnt = 0;
      ren = 1'b1; addr = 4'd4;
      step();
      ren = 1'b0;
      check("post-reset ctrl", rdata, 32'd0);
      check("post-reset rvalid", 32'(rvalid), 32'd1);
      repeat (5) step();
      check("post-reset irq", 32'(wto_irq), 32'd0);

      // PRESCALE=4: ticks fall on edges where edge_cnt % 4 == 0.
      wen4 = 1'b1; addr4 = 3'd1; wdata4 = 32'd3;
      step();
      wen4 = 1'b0;
      for (int k = 0; k < 4 && ((edge_cnt + 1) % 4 != 0); k++) step();
      wen4 = 1'b1; addr4 = 3'd0; wdata4 = 32'd1;
      step();
      wen4 = 1'b0;
      repeat (11) step();
      check("ps4 before expiry", 32'(wto_irq4[0]), 32'd0);
      step();
      check("ps4 expiry at 12", 32'(wto_irq4[0]), 32'd1);

      wen4 = 1'b1; addr4 = 3'd4; wdata4 = 32'd1;
      step();
      wen4 = 1'b0; ren4 = 1'b1; addr4 = 3'd4;
      step();
      check("ps4 ch1 ctrl", rdata4, 32'd1);
      check("ps4 ch1 rvalid", 32'(rvalid4), 32'd1);
      addr4 = 3'd7;
      step();
      ren4 = 1'b0;
      check("ps4 ch1 status", rdata4, 32'd0);
      begin
         logic seen = 1'b0;
         for (int k = 0; k < 1000; k++) begin
            step();
            if (wto_irq4[1]) seen = 1'b1;
         end
         check("ps4 timeout0 no irq", 32'(seen), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
